// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive path.
package hdlc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLAG,
        RECV,
        DONE
    } rx_state_t;

    localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
    localparam int         DEF_FCS_BYTES = 2;

endpackage

// File: rtl/hdlc_sat_counter.sv
// Saturating up-counter; clear together with inc loads 1 (first byte of a frame).
module hdlc_sat_counter #(
    parameter int MAX = 128,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_at_max
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_count != MAXV)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAXV);

endmodule

// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC Rx frame sequencer: opening flag, byte writes, closing flag / abort,
// FCS and size report, single-frame handoff to the host.
module hdlc_rx_frame_ctrl
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 128,
    parameter int FCS_BYTES = DEF_FCS_BYTES,
    parameter int MIN_BYTES = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx_FlagDetect,
    input  logic       Rx_AbortDetect,
    input  logic       Rx_ByteValid,
    input  logic [7:0] Rx_NewByte,
    input  logic       Rx_FCSerr_in,
    input  logic       Rx_Drop,
    input  logic       Rx_FrameRead,
    output logic       Rx_ValidFrame,
    output logic       Rx_WrBuff,
    output logic [7:0] Rx_Data,
    output logic       Rx_EoF,
    output logic       Rx_AbortSignal,
    output logic       Rx_Overflow,
    output logic       Rx_FCSerr,
    output logic [7:0] Rx_FrameSize,
    output logic       Rx_Ready
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    rx_state_t        r_state;
    logic             r_valid, r_wrbuff, r_eof, r_abort, r_ovf, r_fcserr, r_ready;
    logic [7:0]       r_data, r_size;

    logic             w_flag, w_byte, w_start, w_inc, w_at_max, w_runt;
    logic [CNT_W-1:0] w_count, w_size;

    // Priority below RxEN: abort > drop > flag > byte (a byte coinciding with a flag is flag bits)
    assign w_flag  = Rx_FlagDetect & ~Rx_AbortDetect & ~Rx_Drop;
    assign w_byte  = Rx_ByteValid & ~Rx_AbortDetect & ~Rx_Drop & ~Rx_FlagDetect;
    assign w_start = RxEN & (r_state == FLAG) & w_byte;
    assign w_inc   = w_start | (RxEN & (r_state == RECV) & w_byte);
    assign w_runt  = (w_count < CNT_W'(MIN_BYTES));
    assign w_size  = w_count - CNT_W'(FCS_BYTES);

    hdlc_sat_counter #(.MAX(MAX_BYTES), .W(CNT_W)) u_cnt (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_clr    (w_start),
        .i_inc    (w_inc),
        .o_count  (w_count),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_wrbuff <= 1'b0;
            r_data   <= '0;
            r_eof    <= 1'b0;
            r_abort  <= 1'b0;
            r_ovf    <= 1'b0;
            r_fcserr <= 1'b0;
            r_size   <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_wrbuff <= 1'b0;
            r_eof    <= 1'b0;
            r_abort  <= 1'b0;
            if (!RxEN) begin
                // A pending frame survives disable; anything in flight is dropped silently
                if (r_state != DONE) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_flag) r_state <= FLAG;
                    end
                    FLAG: begin
                        if (Rx_AbortDetect || Rx_Drop) begin
                            r_state <= IDLE;
                        end else if (w_byte) begin
                            r_state  <= RECV;
                            r_valid  <= 1'b1;
                            r_wrbuff <= 1'b1;
                            r_data   <= Rx_NewByte;
                            r_ovf    <= 1'b0;
                        end
                    end
                    RECV: begin
                        if (Rx_AbortDetect) begin
                            r_abort <= 1'b1;
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end else if (Rx_Drop) begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end else if (w_flag) begin
                            r_valid <= 1'b0;
                            r_eof   <= 1'b1;
                            if (w_runt) begin
                                r_state <= FLAG;
                            end else begin
                                r_size   <= 8'(w_size);
                                r_fcserr <= Rx_FCSerr_in;
                                r_ready  <= 1'b1;
                                r_state  <= DONE;
                            end
                        end else if (w_byte) begin
                            if (w_at_max) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_wrbuff <= 1'b1;
                                r_data   <= Rx_NewByte;
                            end
                        end
                    end
                    DONE: begin
                        if (Rx_FrameRead || Rx_Drop) begin
                            r_ready  <= 1'b0;
                            r_fcserr <= 1'b0;
                            r_ovf    <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign Rx_ValidFrame  = r_valid;
    assign Rx_WrBuff      = r_wrbuff;
    assign Rx_Data        = r_data;
    assign Rx_EoF         = r_eof;
    assign Rx_AbortSignal = r_abort;
    assign Rx_Overflow    = r_ovf;
    assign Rx_FCSerr      = r_fcserr;
    assign Rx_FrameSize   = r_size;
    assign Rx_Ready       = r_ready;

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Directed bench for hdlc_rx_frame_ctrl with hand-computed expectations.
module tb_hdlc_rx_frame_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       RxEN = 1'b1;
    logic       Rx_FlagDetect = 1'b0, Rx_AbortDetect = 1'b0, Rx_ByteValid = 1'b0;
    logic [7:0] Rx_NewByte = '0;
    logic       Rx_FCSerr_in = 1'b0, Rx_Drop = 1'b0, Rx_FrameRead = 1'b0;
    logic       Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Overflow;
    logic       Rx_FCSerr, Rx_Ready;
    logic [7:0] Rx_Data, Rx_FrameSize;

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int base;

    hdlc_rx_frame_ctrl dut (
        .Clk(Clk), .Rst(Rst), .RxEN(RxEN),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_ByteValid(Rx_ByteValid), .Rx_NewByte(Rx_NewByte),
        .Rx_FCSerr_in(Rx_FCSerr_in), .Rx_Drop(Rx_Drop), .Rx_FrameRead(Rx_FrameRead),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff), .Rx_Data(Rx_Data),
        .Rx_EoF(Rx_EoF), .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow),
        .Rx_FCSerr(Rx_FCSerr), .Rx_FrameSize(Rx_FrameSize), .Rx_Ready(Rx_Ready)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Rx_WrBuff) wr_cnt <= wr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One clock with the given input pulses; outputs are sampled 1 time unit after the edge
    task automatic step(input logic fl, input logic ab, input logic bv, input logic [7:0] b,
                        input logic fcs, input logic dr, input logic rd);
        Rx_FlagDetect = fl; Rx_AbortDetect = ab; Rx_ByteValid = bv; Rx_NewByte = b;
        Rx_FCSerr_in = fcs; Rx_Drop = dr; Rx_FrameRead = rd;
        tick();
        Rx_FlagDetect = 0; Rx_AbortDetect = 0; Rx_ByteValid = 0; Rx_NewByte = '0;
        Rx_FCSerr_in = 0; Rx_Drop = 0; Rx_FrameRead = 0;
    endtask

    task automatic flag(input logic fcs);  step(1, 0, 0, 8'h00, fcs, 0, 0); endtask
    task automatic bytev(input logic [7:0] b); step(0, 0, 1, b, 0, 0, 0); endtask
    task automatic nbytes(input int n);
        for (int i = 0; i < n; i++) bytev(8'(i + 8'h10));
    endtask
    task automatic read_frame(); step(0, 0, 0, 8'h00, 0, 0, 1); endtask

    initial begin
        #200_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        tick(); tick();
        check("rst_vf", Rx_ValidFrame, 0);
        check("rst_outs", {Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Overflow, Rx_FCSerr, Rx_Ready}, 0);
        check("rst_size", Rx_FrameSize, 0);
        Rst = 0;
        tick();

        // 1: 6-byte frame, FrameSize 4
        flag(0);
        check("t1_vf_flag", Rx_ValidFrame, 0);
        for (int i = 1; i <= 6; i++) begin
            bytev(8'(i));
            check("t1_wr", Rx_WrBuff, 1);
            check("t1_data", Rx_Data, 32'(i));
            check("t1_vf", Rx_ValidFrame, 1);
        end
        tick();
        check("t1_wr_idle", Rx_WrBuff, 0);
        flag(0);
        check("t1_eof", Rx_EoF, 1);
        check("t1_vf_end", Rx_ValidFrame, 0);
        check("t1_ready", Rx_Ready, 1);
        check("t1_size", Rx_FrameSize, 4);
        check("t1_fcs", Rx_FCSerr, 0);
        tick();
        check("t1_eof_pulse", Rx_EoF, 0);
        flag(0);
        bytev(8'hAA);
        check("t1_done_ignore_wr", Rx_WrBuff, 0);
        check("t1_done_ready", Rx_Ready, 1);
        read_frame();
        check("t1_read", Rx_Ready, 0);

        // 2: abort mid-frame, then a normal frame
        flag(0); nbytes(3);
        step(0, 1, 0, 8'h00, 0, 0, 0);
        check("t2_abort", Rx_AbortSignal, 1);
        check("t2_vf", Rx_ValidFrame, 0);
        check("t2_ready", Rx_Ready, 0);
        tick();
        check("t2_abort_pulse", Rx_AbortSignal, 0);
        flag(0); nbytes(5); flag(0);
        check("t2_ready2", Rx_Ready, 1);
        check("t2_size", Rx_FrameSize, 3);
        read_frame();

        // 3: overflow, 132 bytes offered
        base = wr_cnt;
        flag(0); nbytes(132); flag(0);
        tick();
        check("t3_wrcnt", wr_cnt - base, 128);
        check("t3_ovf", Rx_Overflow, 1);
        check("t3_size", Rx_FrameSize, 126);
        check("t3_ready", Rx_Ready, 1);
        read_frame();
        check("t3_ovf_clr", Rx_Overflow, 0);

        // 4: runt, closing flag reused as opener
        flag(0); nbytes(2); flag(0);
        check("t4_eof", Rx_EoF, 1);
        check("t4_ready", Rx_Ready, 0);
        nbytes(4); flag(0);
        check("t4_ready2", Rx_Ready, 1);
        check("t4_size", Rx_FrameSize, 2);
        read_frame();

        // 5: FCS error, drop, flag+byte coincidence
        flag(0); nbytes(4); flag(1);
        check("t5_fcs", Rx_FCSerr, 1);
        check("t5_ready", Rx_Ready, 1);
        step(0, 0, 0, 8'h00, 0, 1, 0);
        check("t5_drop_ready", Rx_Ready, 0);
        check("t5_drop_fcs", Rx_FCSerr, 0);
        flag(0); nbytes(5);
        step(1, 0, 1, 8'h55, 0, 0, 0);
        check("t5_fb_wr", Rx_WrBuff, 0);
        check("t5_fb_eof", Rx_EoF, 1);
        check("t5_fb_size", Rx_FrameSize, 3);
        read_frame();

        // 6: reset and disable mid-frame
        flag(0); nbytes(3);
        Rst = 1;
        #1;
        check("t6_rst_vf", Rx_ValidFrame, 0);
        tick();
        check("t6_rst_outs", {Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Ready}, 0);
        Rst = 0;
        tick();
        flag(0); nbytes(2);
        RxEN = 0;
        tick();
        check("t6_en_vf", Rx_ValidFrame, 0);
        check("t6_en_outs", {Rx_EoF, Rx_AbortSignal, Rx_WrBuff}, 0);
        RxEN = 1;
        bytev(8'h33);
        check("t6_idle_nowr", Rx_WrBuff, 0);
        flag(0); nbytes(6); flag(0);
        check("t6_size", Rx_FrameSize, 4);
        check("t6_ready", Rx_Ready, 1);
        RxEN = 0;
        tick();
        check("t6_done_kept", Rx_Ready, 1);
        RxEN = 1;
        read_frame();
        check("t6_read", Rx_Ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
